// File: rtl/alu_pkg.sv
// Shared opcode, flag and FSM definitions for the ALU request scheduler.
// Latency: n/a (type and constant package only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_SLT  = 4'hA;
    localparam logic [3:0] OP_LAST = OP_SLT;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_req_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Round-robin one-hot grant; search begins one past the last granted index.
// Latency: purely combinational, the caller owns the pointer register.
// Backpressure: none, grants whatever is requested this cycle.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N);
            if (req[idx] && (gnt == '0)) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one registered ALU between NUM_REQ requesters; optional ALU_SCHED_PRIO_EN gives requester 0 strict priority.
// Latency: legal op accept T -> alu_en T+1 -> capture T+2 -> resp_valid T+3; illegal op resp_valid T+1.
// Backpressure: response held until resp_ready; no request is accepted until the response drains.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*4-1:0] req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [7:0]           resp_out,
    output logic [3:0]           resp_flags,
    output logic                 resp_err,
    output logic                 alu_en,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_op,
    input  logic [7:0]           alu_out,
    input  logic [3:0]           alu_flags
);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] gnt_rr;
    logic [ID_W-1:0]    gnt_idx_rr;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    alu_req_t           sel;

`ifdef ALU_SCHED_PRIO_EN
    // Requester 0 bypasses the ring; the others rotate among themselves.
    assign arb_req = {req_valid[NUM_REQ-1:1], 1'b0};
`else
    assign arb_req = req_valid;
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req     (arb_req),
        .ptr     (ptr),
        .gnt     (gnt_rr),
        .gnt_idx (gnt_idx_rr)
    );

    always_comb begin
        gnt     = gnt_rr;
        gnt_idx = gnt_idx_rr;
`ifdef ALU_SCHED_PRIO_EN
        if (req_valid[0]) begin
            gnt     = NUM_REQ'(1);
            gnt_idx = '0;
        end
`endif
    end

    always_comb begin
        sel.op = req_op[4*gnt_idx +: 4];
        sel.a  = req_a[8*gnt_idx +: 8];
        sel.b  = req_b[8*gnt_idx +: 8];
    end

    // Accept is same-cycle so a requester that drops valid is never granted.
    assign req_ready = (state == IDLE && !rst) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= ID_W'(NUM_REQ - 1);
            alu_en     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_out   <= '0;
            resp_flags <= '0;
            resp_err   <= 1'b0;
        end else begin
            alu_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        ptr     <= gnt_idx;
                        resp_id <= gnt_idx;
                        if (op_legal(sel.op)) begin
                            alu_en <= 1'b1;
                            alu_a  <= sel.a;
                            alu_b  <= sel.b;
                            alu_op <= sel.op;
                            state  <= ISSUE;
                        end else begin
                            resp_out   <= '0;
                            resp_flags <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    resp_out   <= alu_out;
                    resp_flags <= alu_flags;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a registered ALU model on the alu_* side.
module tb_alu_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a = '0;
    logic [NUM_REQ*8-1:0] req_b = '0;
    logic [NUM_REQ*4-1:0] req_op = '0;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [ID_W-1:0]      resp_id;
    logic [7:0]           resp_out;
    logic [3:0]           resp_flags;
    logic                 resp_err;
    logic                 alu_en;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [3:0]           alu_op;
    logic [7:0]           alu_out = '0;
    logic [3:0]           alu_flags = '0;

    int checks   = 0;
    int failures = 0;

    alu_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .resp_flags (resp_flags),
        .resp_err   (resp_err),
        .alu_en     (alu_en),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags)
    );

    always #5 clk = ~clk;

    // Reference ALU: ADD/SUB with {N,Z,V,C}; C on SUB is borrow.
    function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] op);
        logic [8:0] r;
        logic       v;
        r = '0;
        v = 1'b0;
        case (op)
            4'h0: begin
                r = {1'b0, a} + {1'b0, b};
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h1: begin
                r = {1'b0, a} - {1'b0, b};
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            default: r = {1'b0, a ^ b};
        endcase
        return {r[7:0], r[7], (r[7:0] == 8'h00), v, r[8]};
    endfunction

    always @(posedge clk) begin
        if (alu_en) {alu_out, alu_flags} <= alu_model(alu_a, alu_b, alu_op);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_regs(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
        chk({tag, "_resp_id"},    32'(resp_id),    0);
        chk({tag, "_resp_out"},   32'(resp_out),   0);
        chk({tag, "_resp_flags"}, 32'(resp_flags), 0);
        chk({tag, "_resp_err"},   32'(resp_err),   0);
        chk({tag, "_alu_en"},     32'(alu_en),     0);
        chk({tag, "_alu_a"},      32'(alu_a),      0);
        chk({tag, "_alu_b"},      32'(alu_b),      0);
        chk({tag, "_alu_op"},     32'(alu_op),     0);
    endtask

    // Single legal op from one requester, starting and ending in IDLE at a negedge.
    task automatic do_op(input string tag, input int idx, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] eo, input logic [3:0] ef);
        req_a[8*idx +: 8]  = a;
        req_b[8*idx +: 8]  = b;
        req_op[4*idx +: 4] = op;
        req_valid = NUM_REQ'(1 << idx);
        resp_ready = 1'b0;
        #1 chk({tag, "_grant"}, 32'(req_ready), 32'(1 << idx));
        step();
        req_valid = '0;
        #1 chk({tag, "_en_T1"}, 32'(alu_en), 1);
        chk({tag, "_alu_a"},  32'(alu_a),  32'(a));
        chk({tag, "_alu_b"},  32'(alu_b),  32'(b));
        chk({tag, "_alu_op"}, 32'(alu_op), 32'(op));
        step();
        #1 chk({tag, "_en_T2"}, 32'(alu_en), 0);
        chk({tag, "_vld_T2"}, 32'(resp_valid), 0);
        step();
        resp_ready = 1'b1;
        #1 chk({tag, "_vld_T3"}, 32'(resp_valid), 1);
        chk({tag, "_id"},    32'(resp_id),    32'(idx));
        chk({tag, "_out"},   32'(resp_out),   32'(eo));
        chk({tag, "_flags"}, 32'(resp_flags), 32'(ef));
        chk({tag, "_err"},   32'(resp_err),   0);
        step();
        resp_ready = 1'b0;
        #1 chk({tag, "_vld_done"}, 32'(resp_valid), 0);
    endtask

    initial begin
        logic [7:0] exp_out [NUM_REQ];
        int g;
        exp_out[0] = 8'h10;
        exp_out[1] = 8'h21;
        exp_out[2] = 8'h32;
        exp_out[3] = 8'h43;

        // Reset with every requester asserting valid: nothing may be accepted.
        rst = 1'b1;
        req_valid = '1;
        step();
        step();
        #1 chk_reset_regs("rst");
        chk("rst_req_ready", 32'(req_ready), 0);
        step();
        rst = 1'b0;
        req_valid = '0;

        do_op("add_ovf", 0, 8'h7F, 8'h01, 4'h0, 8'h80, 4'b1010);
        do_op("add_carry", 2, 8'hFF, 8'h01, 4'h0, 8'h00, 4'b0101);
        do_op("sub_zero", 2, 8'h05, 8'h05, 4'h1, 8'h00, 4'b0100);

        // Saturated load from a fresh reset: one grant every 4 cycles.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[8*i +: 8]  = 8'(16 * (i + 1));
            req_b[8*i +: 8]  = 8'(i);
            req_op[4*i +: 4] = 4'h0;
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
`ifdef ALU_SCHED_PRIO_EN
            g = 0;
`else
            g = (k / 4) % NUM_REQ;
`endif
            #1 chk("rr_ready", 32'(req_ready), (k % 4 == 0) ? 32'(1 << g) : 0);
            chk("rr_alu_en", 32'(alu_en), (k % 4 == 1) ? 1 : 0);
            chk("rr_resp_valid", 32'(resp_valid), (k % 4 == 3) ? 1 : 0);
            if (k % 4 == 3) begin
                chk("rr_resp_id", 32'(resp_id), 32'(g));
                chk("rr_resp_out", 32'(resp_out), 32'(exp_out[g]));
            end
            step();
        end

        // Illegal opcode from requester 1: immediate error response, ALU untouched.
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        req_op[7:4] = 4'hC;
        #1 chk("ill_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = '1;
        #1 chk("ill_alu_en", 32'(alu_en), 0);
        chk("ill_alu_a_hold", 32'(alu_a), 32'h10);
        chk("ill_err", 32'(resp_err), 1);
        chk("ill_out", 32'(resp_out), 0);
        chk("ill_flags", 32'(resp_flags), 0);

        // Hold the response under backpressure with all requesters pending.
        for (int j = 0; j < 10; j++) begin
            #1 chk("hold_valid", 32'(resp_valid), 1);
            chk("hold_id", 32'(resp_id), 1);
            chk("hold_err", 32'(resp_err), 1);
            chk("hold_ready_quiet", 32'(req_ready), 0);
            chk("hold_alu_en", 32'(alu_en), 0);
            step();
        end
        resp_ready = 1'b1;
        #1 chk("drain_valid", 32'(resp_valid), 1);
        chk("drain_no_grant", 32'(req_ready), 0);
        step();
        resp_ready = 1'b0;
`ifdef ALU_SCHED_PRIO_EN
        #1 chk("drain_done", 32'(resp_valid), 0);
        chk("post_drain_grant", 32'(req_ready), 32'h1);
`else
        #1 chk("drain_done", 32'(resp_valid), 0);
        chk("post_drain_grant", 32'(req_ready), 32'h4);
`endif
        step();
        req_valid = '0;
`ifdef ALU_SCHED_PRIO_EN
        #1 chk("abort_issue_a", 32'(alu_a), 32'h10);
`else
        #1 chk("abort_issue_a", 32'(alu_a), 32'h30);
`endif
        chk("abort_issue_en", 32'(alu_en), 1);
        step();
        rst = 1'b1;
        #1 chk("abort_capture_vld", 32'(resp_valid), 0);
        step();
        rst = 1'b0;
        req_valid = '1;
        #1 chk_reset_regs("abort");
        chk("abort_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        step();
        resp_ready = 1'b1;
        #1 chk("post_abort_valid", 32'(resp_valid), 1);
        chk("post_abort_id", 32'(resp_id), 0);
        chk("post_abort_out", 32'(resp_out), 32'h10);
        step();
        resp_ready = 1'b0;
        #1 chk("post_abort_done", 32'(resp_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
